ifetch_queue: RTL

IFETCH_QUEUE -- requirements
Module: ifetch_queue

---
 rtl/ifetch_pkg.sv | 16 +
 rtl/sync_fifo.sv | 54 +++++
 rtl/ifetch_queue.sv | 135 +++++++++++++
 3 files changed

// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch queue.
package ifetch_pkg;

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } ifq_entry_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous clear; head is the oldest entry, valid when !empty.
module sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned AW = $clog2(DEPTH),
    localparam int unsigned CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign head  = mem[rd_ptr];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/ifetch_queue.sv
// Instruction fetch queue: credit-limited fetch issue, PC tagging, redirect drop and decode buffer.
// Build option IFETCH_QUEUE_BYPASS_EN forwards a response straight to decode when the queue is empty.
module ifetch_queue
    import ifetch_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned SW = CW + 2;

    logic [31:0]   fetch_pc;
    logic [CW-1:0] drop_cnt;
    logic [CW-1:0] q_count;
    logic [CW-1:0] tag_count;
    logic          q_full;
    logic          q_empty;
    logic          tag_full;
    logic          tag_empty;
    ifq_entry_t    q_head;
    ifq_entry_t    q_wdata;
    logic [31:0]   tag_head;
    logic [SW-1:0] outstanding;
    logic [SW-1:0] live_inflight;
    logic          req_fire;
    logic          rsp_drop;
    logic          rsp_take;
    logic          bypass_fire;
    logic          q_push;
    logic          q_pop;
    logic          unused_flags;

    // Every issued fetch holds a credit until it leaves the queue or is dropped.
    assign outstanding    = SW'(q_count) + SW'(tag_count) + SW'(drop_cnt);
    assign imem_req_valid = rst && !redirect_valid && (outstanding < SW'(DEPTH));
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign rsp_drop = imem_rsp_valid && (drop_cnt != '0);
    assign rsp_take = imem_rsp_valid && (drop_cnt == '0) && !redirect_valid;
    assign q_wdata  = '{pc: tag_head, instr: imem_rsp_data};

`ifdef IFETCH_QUEUE_BYPASS_EN
    assign bypass_fire = rsp_take && q_empty && out_ready;
`else
    assign bypass_fire = 1'b0;
`endif

    assign q_push = rsp_take && !bypass_fire;
    assign q_pop  = out_ready && !q_empty && !redirect_valid;

    // Responses still owed by memory at a redirect, less any one retiring this cycle.
    assign live_inflight = SW'(tag_count) + SW'(drop_cnt) - SW'(imem_rsp_valid);

    always_ff @(posedge clk) begin
        if (!rst) begin
            fetch_pc <= word_align(RESET_PC);
            drop_cnt <= '0;
        end else if (redirect_valid) begin
            fetch_pc <= word_align(redirect_pc);
            drop_cnt <= CW'(live_inflight);
        end else begin
            if (req_fire) fetch_pc <= fetch_pc + 32'd4;
            if (rsp_drop) drop_cnt <= drop_cnt - CW'(1);
        end
    end

    always_comb begin
        out_valid = 1'b0;
        out_pc    = '0;
        out_instr = '0;
        if (rst && !q_empty) begin
            out_valid = 1'b1;
            out_pc    = q_head.pc;
            out_instr = q_head.instr;
        end
`ifdef IFETCH_QUEUE_BYPASS_EN
        else if (rst && rsp_take) begin
            out_valid = 1'b1;
            out_pc    = tag_head;
            out_instr = imem_rsp_data;
        end
`endif
    end

    sync_fifo #(
        .WIDTH ($bits(ifq_entry_t)),
        .DEPTH (DEPTH)
    ) u_entry_q (
        .clk       (clk),
        .rst       (rst),
        .clear     (redirect_valid),
        .push      (q_push),
        .push_data (q_wdata),
        .pop       (q_pop),
        .head      (q_head),
        .full      (q_full),
        .empty     (q_empty),
        .count     (q_count)
    );

    sync_fifo #(
        .WIDTH (32),
        .DEPTH (DEPTH)
    ) u_tag_q (
        .clk       (clk),
        .rst       (rst),
        .clear     (redirect_valid),
        .push      (req_fire),
        .push_data (fetch_pc),
        .pop       (rsp_take),
        .head      (tag_head),
        .full      (tag_full),
        .empty     (tag_empty),
        .count     (tag_count)
    );

    assign unused_flags = ^{q_full, tag_full, tag_empty};

endmodule
